// File: rtl/hazard_detection_unit_if.sv
// Hazard detection unit interface: groups the pipeline-facing hazard inputs
// and the stall/flush/halt outputs. The pipeline side drives through the
// master modport; the hazard detection unit receives through the slave modport.
interface hazard_detection_unit_if #(
  parameter int CNT_W = 32
);
  logic             i_run_en;
  logic [4:0]       i_rs_ID;
  logic [4:0]       i_rt_ID;
  logic             i_uses_rs_ID;
  logic             i_uses_rt_ID;
  logic             i_branch_ID;
  logic             i_branch_taken_ID;
  logic             i_jump_ID;
  logic [4:0]       i_rt_EX;
  logic [4:0]       i_rd_EX;
  logic [1:0]       i_flg_ALU_dst_EX;
  logic             i_flg_reg_wr_en_EX;
  logic             i_flg_mem_rd_EX;
  logic [4:0]       i_rt_MEM;
  logic [4:0]       i_rd_MEM;
  logic [1:0]       i_flg_ALU_dst_MEM;
  logic             i_flg_reg_wr_en_MEM;
  logic             i_flg_mem_rd_MEM;
  logic             i_halt_WB;
  logic             o_pc_wr_en;
  logic             o_IF_ID_wr_en;
  logic             o_ID_EX_bubble;
  logic             o_IF_ID_flush;
  logic             o_halted;
  logic [CNT_W-1:0] o_stall_count;
  logic [CNT_W-1:0] o_flush_count;

  modport master (
    output i_run_en, i_rs_ID, i_rt_ID, i_uses_rs_ID, i_uses_rt_ID,
           i_branch_ID, i_branch_taken_ID, i_jump_ID,
           i_rt_EX, i_rd_EX, i_flg_ALU_dst_EX, i_flg_reg_wr_en_EX, i_flg_mem_rd_EX,
           i_rt_MEM, i_rd_MEM, i_flg_ALU_dst_MEM, i_flg_reg_wr_en_MEM, i_flg_mem_rd_MEM,
           i_halt_WB,
    input  o_pc_wr_en, o_IF_ID_wr_en, o_ID_EX_bubble, o_IF_ID_flush, o_halted,
           o_stall_count, o_flush_count
  );

  modport slave (
    input  i_run_en, i_rs_ID, i_rt_ID, i_uses_rs_ID, i_uses_rt_ID,
           i_branch_ID, i_branch_taken_ID, i_jump_ID,
           i_rt_EX, i_rd_EX, i_flg_ALU_dst_EX, i_flg_reg_wr_en_EX, i_flg_mem_rd_EX,
           i_rt_MEM, i_rd_MEM, i_flg_ALU_dst_MEM, i_flg_reg_wr_en_MEM, i_flg_mem_rd_MEM,
           i_halt_WB,
    output o_pc_wr_en, o_IF_ID_wr_en, o_ID_EX_bubble, o_IF_ID_flush, o_halted,
           o_stall_count, o_flush_count
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: resolves the hazards the EX forwarding unit cannot
// (load-use and ID-stage branch compare operands) by stalling PC and IF/ID and
// bubbling ID/EX, flushes IF/ID on taken control transfers, owns the halt
// state and keeps saturating stall/flush performance counters.
// Stall and flush outputs are Mealy so they act on the same edge as the hazard.
module hazard_detection_unit #(
  parameter int CNT_W = 32
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  hazard_detection_unit_if.slave hdu
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STALL2 = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             match_ex;
  logic             match_mem;
  logic             h_lu;
  logic             h_ba;
  logic             h_bl2;
  logic             h_bl1;
  logic             any_hazard;
  logic             bubble;
  logic             flush;

  // A stage matches when it really writes a nonzero register that the ID
  // instruction reads; select 10, no write enable, or r0 never match.
  function automatic logic stage_match(
    input logic [1:0] sel,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic       wr_en,
    input logic [4:0] rs_id,
    input logic [4:0] rt_id,
    input logic       uses_rs,
    input logic       uses_rt
  );
    logic [4:0] dst;
    logic       valid;
    case (sel)
      2'b00:   dst = rt;
      2'b01:   dst = rd;
      2'b11:   dst = 5'd31;
      default: dst = 5'd0;
    endcase
    valid = wr_en && (sel != 2'b10) && (dst != 5'd0);
    return valid && ((uses_rs && (rs_id == dst)) || (uses_rt && (rt_id == dst)));
  endfunction

  // Hazard terms from the current ID, EX and MEM contents.
  always_comb begin
    match_ex   = stage_match(hdu.i_flg_ALU_dst_EX, hdu.i_rt_EX, hdu.i_rd_EX,
                             hdu.i_flg_reg_wr_en_EX, hdu.i_rs_ID, hdu.i_rt_ID,
                             hdu.i_uses_rs_ID, hdu.i_uses_rt_ID);
    match_mem  = stage_match(hdu.i_flg_ALU_dst_MEM, hdu.i_rt_MEM, hdu.i_rd_MEM,
                             hdu.i_flg_reg_wr_en_MEM, hdu.i_rs_ID, hdu.i_rt_ID,
                             hdu.i_uses_rs_ID, hdu.i_uses_rt_ID);
    h_lu       = hdu.i_flg_mem_rd_EX & match_ex;
    h_ba       = hdu.i_branch_ID & ~hdu.i_flg_mem_rd_EX & match_ex;
    h_bl2      = hdu.i_branch_ID & hdu.i_flg_mem_rd_EX & match_ex;
    h_bl1      = hdu.i_branch_ID & hdu.i_flg_mem_rd_MEM & match_mem;
    any_hazard = h_lu | h_ba | h_bl2 | h_bl1;
  end

  // Pipeline control outputs in priority order: reset, halted, frozen,
  // second stall cycle, hazard stall, taken flush, normal flow.
  always_comb begin
    hdu.o_pc_wr_en     = 1'b0;
    hdu.o_IF_ID_wr_en  = 1'b0;
    bubble             = 1'b0;
    flush              = 1'b0;
    hdu.o_halted       = 1'b0;
    if (!i_rst_n) begin
    end else if (state == ST_HALTED) begin
      hdu.o_halted = 1'b1;
    end else if (!hdu.i_run_en) begin
    end else if ((state == ST_STALL2) || any_hazard) begin
      bubble = 1'b1;
    end else begin
      hdu.o_pc_wr_en    = 1'b1;
      hdu.o_IF_ID_wr_en = 1'b1;
      flush             = hdu.i_branch_taken_ID | hdu.i_jump_ID;
    end
    hdu.o_ID_EX_bubble = bubble;
    hdu.o_IF_ID_flush  = flush;
    hdu.o_stall_count  = stall_count;
    hdu.o_flush_count  = flush_count;
  end

  // FSM and saturating counters; everything holds while frozen or halted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      stall_count <= '0;
      flush_count <= '0;
    end else if ((state != ST_HALTED) && hdu.i_run_en) begin
      if (hdu.i_halt_WB) begin
        state <= ST_HALTED;
      end else if (state == ST_STALL2) begin
        state <= ST_RUN;
      end else if (h_bl2) begin
        state <= ST_STALL2;
      end else begin
        state <= ST_RUN;
      end
      if (bubble && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Testbench for hazard_detection_unit: directed vectors with literal pins plus
// a per-cycle comparison against a stall-budget model of the pipeline control.
module tb_hazard_detection_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  hazard_detection_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_detection_unit #(.CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hdu     (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Model state: remaining forced stall cycles, halt flag, counters
  int m_pending;
  bit m_halted;
  int m_stall;
  int m_flush;
  int e_pc, e_ifid, e_bubble, e_flush, e_halted;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int dstOf(input logic [1:0] sel, input logic [4:0] rt,
                               input logic [4:0] rd, input logic wr);
    int r;
    if (!wr) return -1;
    case (sel)
      2'b00:   r = int'(rt);
      2'b01:   r = int'(rd);
      2'b11:   r = 31;
      default: r = -1;
    endcase
    if (r == 0) r = -1;
    return r;
  endfunction

  function automatic bit readsReg(input int r);
    if (r < 0) return 1'b0;
    return (bus.i_uses_rs_ID && int'(bus.i_rs_ID) == r) ||
           (bus.i_uses_rt_ID && int'(bus.i_rt_ID) == r);
  endfunction

  // Number of cycles the ID instruction must wait before it can proceed
  function automatic int stallsNeeded();
    int n = 0;
    int ex  = dstOf(bus.i_flg_ALU_dst_EX, bus.i_rt_EX, bus.i_rd_EX, bus.i_flg_reg_wr_en_EX);
    int mem = dstOf(bus.i_flg_ALU_dst_MEM, bus.i_rt_MEM, bus.i_rd_MEM, bus.i_flg_reg_wr_en_MEM);
    if (readsReg(ex)) begin
      if (bus.i_flg_mem_rd_EX) n = bus.i_branch_ID ? 2 : 1;
      else if (bus.i_branch_ID) n = 1;
    end
    if (bus.i_branch_ID && bus.i_flg_mem_rd_MEM && readsReg(mem) && n < 1) n = 1;
    return n;
  endfunction

  // Compare process: predict on the falling edge, advance on the rising edge
  initial begin
    m_pending = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    forever begin
      @(negedge clk);
      e_pc = 0; e_ifid = 0; e_bubble = 0; e_flush = 0; e_halted = 0;
      if (!rst_n) begin
        m_pending = 0; m_halted = 0; m_stall = 0; m_flush = 0;
      end else if (m_halted) begin
        e_halted = 1;
      end else if (!bus.i_run_en) begin
      end else if (m_pending > 0 || stallsNeeded() > 0) begin
        e_bubble = 1;
      end else begin
        e_pc = 1; e_ifid = 1;
        e_flush = (bus.i_branch_taken_ID || bus.i_jump_ID) ? 1 : 0;
      end
      checkOutput("model_pc_wr_en", int'(bus.o_pc_wr_en), e_pc);
      checkOutput("model_IF_ID_wr_en", int'(bus.o_IF_ID_wr_en), e_ifid);
      checkOutput("model_bubble", int'(bus.o_ID_EX_bubble), e_bubble);
      checkOutput("model_flush", int'(bus.o_IF_ID_flush), e_flush);
      checkOutput("model_halted", int'(bus.o_halted), e_halted);
      checkOutput("model_stall_count", int'(bus.o_stall_count), m_stall);
      checkOutput("model_flush_count", int'(bus.o_flush_count), m_flush);
      @(posedge clk);
      if (!rst_n) begin
        m_pending = 0; m_halted = 0; m_stall = 0; m_flush = 0;
      end else if (!m_halted && bus.i_run_en) begin
        if (bus.i_halt_WB) m_halted = 1;
        else if (m_pending > 0) m_pending--;
        else if (stallsNeeded() > 0) m_pending = stallsNeeded() - 1;
        if (e_bubble == 1 && m_stall < CNT_MAX) m_stall++;
        if (e_flush == 1 && m_flush < CNT_MAX) m_flush++;
      end
    end
  end

  // Advance to just after the next rising edge and return inputs to idle
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    bus.i_run_en = 1'b1;
    bus.i_rs_ID = '0; bus.i_rt_ID = '0; bus.i_uses_rs_ID = 1'b0; bus.i_uses_rt_ID = 1'b0;
    bus.i_branch_ID = 1'b0; bus.i_branch_taken_ID = 1'b0; bus.i_jump_ID = 1'b0;
    bus.i_rt_EX = '0; bus.i_rd_EX = '0; bus.i_flg_ALU_dst_EX = 2'b10;
    bus.i_flg_reg_wr_en_EX = 1'b0; bus.i_flg_mem_rd_EX = 1'b0;
    bus.i_rt_MEM = '0; bus.i_rd_MEM = '0; bus.i_flg_ALU_dst_MEM = 2'b10;
    bus.i_flg_reg_wr_en_MEM = 1'b0; bus.i_flg_mem_rd_MEM = 1'b0;
    bus.i_halt_WB = 1'b0;
  endtask

  task automatic loadInEx(input logic [4:0] rt);
    bus.i_rt_EX = rt; bus.i_flg_ALU_dst_EX = 2'b00;
    bus.i_flg_reg_wr_en_EX = 1'b1; bus.i_flg_mem_rd_EX = 1'b1;
  endtask

  // Directed stimulus with hand-computed pins
  initial begin
    rst_n = 1'b0;
    bus.i_run_en = 1'b1; bus.i_halt_WB = 1'b0;
    #2;
    checkOutput("reset_pc_wr_en", int'(bus.o_pc_wr_en), 0);
    checkOutput("reset_halted", int'(bus.o_halted), 0);
    applyStimulus();
    rst_n = 1'b1;
    #3;
    checkOutput("idle_pc_wr_en", int'(bus.o_pc_wr_en), 1);

    // Load-use: one stall, then free flow
    applyStimulus();
    loadInEx(5'd5); bus.i_rs_ID = 5'd5; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("lu_pc_wr_en", int'(bus.o_pc_wr_en), 0);
    checkOutput("lu_bubble", int'(bus.o_ID_EX_bubble), 1);
    applyStimulus();
    bus.i_rs_ID = 5'd5; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("lu_after_pc", int'(bus.o_pc_wr_en), 1);
    checkOutput("lu_stall_count", int'(bus.o_stall_count), 1);

    // Branch after load: two stalls
    applyStimulus();
    loadInEx(5'd7); bus.i_branch_ID = 1'b1; bus.i_rs_ID = 5'd7; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("bl_first_bubble", int'(bus.o_ID_EX_bubble), 1);
    applyStimulus();
    bus.i_branch_ID = 1'b1; bus.i_rs_ID = 5'd7; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("bl_second_bubble", int'(bus.o_ID_EX_bubble), 1);
    applyStimulus();
    bus.i_branch_ID = 1'b1; bus.i_rs_ID = 5'd7; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("bl_release_bubble", int'(bus.o_ID_EX_bubble), 0);
    checkOutput("bl_stall_count", int'(bus.o_stall_count), 3);

    // Branch after ALU op, then the no-destination cases
    applyStimulus();
    bus.i_flg_ALU_dst_EX = 2'b01; bus.i_rd_EX = 5'd3; bus.i_flg_reg_wr_en_EX = 1'b1;
    bus.i_branch_ID = 1'b1; bus.i_rt_ID = 5'd3; bus.i_uses_rt_ID = 1'b1;
    #3;
    checkOutput("ba_bubble", int'(bus.o_ID_EX_bubble), 1);
    applyStimulus();
    bus.i_flg_ALU_dst_EX = 2'b01; bus.i_rd_EX = 5'd0; bus.i_flg_reg_wr_en_EX = 1'b1;
    bus.i_branch_ID = 1'b1; bus.i_rt_ID = 5'd0; bus.i_uses_rt_ID = 1'b1;
    #3;
    checkOutput("ba_r0_bubble", int'(bus.o_ID_EX_bubble), 0);
    applyStimulus();
    bus.i_flg_ALU_dst_EX = 2'b10; bus.i_rd_EX = 5'd3; bus.i_flg_reg_wr_en_EX = 1'b1;
    bus.i_branch_ID = 1'b1; bus.i_rt_ID = 5'd3; bus.i_uses_rt_ID = 1'b1;
    #3;
    checkOutput("ba_none_bubble", int'(bus.o_ID_EX_bubble), 0);
    applyStimulus();
    bus.i_flg_ALU_dst_EX = 2'b01; bus.i_rd_EX = 5'd3; bus.i_flg_reg_wr_en_EX = 1'b1;
    bus.i_rt_ID = 5'd3; bus.i_uses_rt_ID = 1'b1;
    #3;
    checkOutput("alu_fwd_bubble", int'(bus.o_ID_EX_bubble), 0);
    applyStimulus();
    bus.i_flg_ALU_dst_MEM = 2'b00; bus.i_rt_MEM = 5'd9; bus.i_flg_reg_wr_en_MEM = 1'b1;
    bus.i_flg_mem_rd_MEM = 1'b1; bus.i_branch_ID = 1'b1; bus.i_rs_ID = 5'd9; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("bl1_bubble", int'(bus.o_ID_EX_bubble), 1);
    applyStimulus();
    bus.i_flg_ALU_dst_EX = 2'b11; bus.i_flg_reg_wr_en_EX = 1'b1;
    bus.i_branch_ID = 1'b1; bus.i_rt_ID = 5'd31; bus.i_uses_rt_ID = 1'b1;
    #3;
    checkOutput("r31_bubble", int'(bus.o_ID_EX_bubble), 1);

    // Taken branch flushes; a hazard masks the flush; jump flushes
    applyStimulus();
    bus.i_branch_ID = 1'b1; bus.i_branch_taken_ID = 1'b1;
    #3;
    checkOutput("taken_flush", int'(bus.o_IF_ID_flush), 1);
    checkOutput("taken_pc", int'(bus.o_pc_wr_en), 1);
    checkOutput("taken_stall_count", int'(bus.o_stall_count), 6);
    applyStimulus();
    bus.i_flg_ALU_dst_EX = 2'b01; bus.i_rd_EX = 5'd4; bus.i_flg_reg_wr_en_EX = 1'b1;
    bus.i_branch_ID = 1'b1; bus.i_branch_taken_ID = 1'b1; bus.i_rs_ID = 5'd4; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("taken_flush_count", int'(bus.o_flush_count), 1);
    checkOutput("masked_flush", int'(bus.o_IF_ID_flush), 0);
    checkOutput("masked_bubble", int'(bus.o_ID_EX_bubble), 1);
    applyStimulus();
    bus.i_jump_ID = 1'b1;
    #3;
    checkOutput("jump_flush", int'(bus.o_IF_ID_flush), 1);
    applyStimulus();
    #3;
    checkOutput("jump_flush_count", int'(bus.o_flush_count), 2);

    // Frozen by the debug unit: enables low, counters hold
    applyStimulus();
    bus.i_run_en = 1'b0; loadInEx(5'd5); bus.i_rs_ID = 5'd5; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("frozen_pc", int'(bus.o_pc_wr_en), 0);
    checkOutput("frozen_bubble", int'(bus.o_ID_EX_bubble), 0);
    applyStimulus();
    bus.i_run_en = 1'b0; loadInEx(5'd5); bus.i_rs_ID = 5'd5; bus.i_uses_rs_ID = 1'b1;
    #3;
    checkOutput("frozen_stall_count", int'(bus.o_stall_count), 7);

    // Repeated load-use stalls drive the stall counter into saturation
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      loadInEx(5'd5); bus.i_rs_ID = 5'd5; bus.i_uses_rs_ID = 1'b1;
    end
    applyStimulus();
    #3;
    checkOutput("sat_stall_count", int'(bus.o_stall_count), CNT_MAX);

    // Asynchronous reset while in the second stall cycle
    applyStimulus();
    loadInEx(5'd7); bus.i_branch_ID = 1'b1; bus.i_rs_ID = 5'd7; bus.i_uses_rs_ID = 1'b1;
    applyStimulus();
    bus.i_branch_ID = 1'b1; bus.i_rs_ID = 5'd7; bus.i_uses_rs_ID = 1'b1;
    #1;
    checkOutput("stall2_bubble", int'(bus.o_ID_EX_bubble), 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_bubble", int'(bus.o_ID_EX_bubble), 0);
    checkOutput("async_pc", int'(bus.o_pc_wr_en), 0);
    checkOutput("async_stall_count", int'(bus.o_stall_count), 0);
    checkOutput("async_flush_count", int'(bus.o_flush_count), 0);
    applyStimulus();
    rst_n = 1'b1;
    #3;
    checkOutput("post_reset_pc", int'(bus.o_pc_wr_en), 1);
    checkOutput("post_reset_halted", int'(bus.o_halted), 0);

    // Halt: current cycle still flows, then sticky halt
    applyStimulus();
    bus.i_halt_WB = 1'b1;
    #3;
    checkOutput("halt_cycle_pc", int'(bus.o_pc_wr_en), 1);
    applyStimulus();
    loadInEx(5'd5); bus.i_rs_ID = 5'd5; bus.i_uses_rs_ID = 1'b1; bus.i_branch_taken_ID = 1'b1;
    #3;
    checkOutput("halted_flag", int'(bus.o_halted), 1);
    checkOutput("halted_pc", int'(bus.o_pc_wr_en), 0);
    checkOutput("halted_bubble", int'(bus.o_ID_EX_bubble), 0);
    applyStimulus();
    bus.i_jump_ID = 1'b1;
    #3;
    checkOutput("halted_sticky", int'(bus.o_halted), 1);
    checkOutput("halted_flush", int'(bus.o_IF_ID_flush), 0);

    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Consumer-side counterpart of the EX-stage forwarding unit. Forwarding resolves RAW hazards by steering ALU operands; this block resolves the hazards forwarding cannot:
  - load-use;
  - operands of an ID-stage branch compare.
- It stalls PC and IF/ID, inserts bubbles into ID/EX, and flushes IF/ID on taken control transfers.
- It owns the pipeline halt state and the stall/flush performance counters.
- Sits in the top-level pipeline, between the control unit, the pipeline registers and the debug unit.

Parameters:
- CNT_W, 32: width of the o_stall_count and o_flush_count performance counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_run_en  in  1  debug-unit gate; 0 freezes the pipeline.
- i_rs_ID  in  5  rs of the ID instruction.
- i_rt_ID  in  5  rt of the ID instruction.
- i_uses_rs_ID  in  1  ID instruction reads rs.
- i_uses_rt_ID  in  1  ID instruction reads rt.
- i_branch_ID  in  1  ID instruction is a conditional branch (compare performed in ID).
- i_branch_taken_ID  in  1  branch resolved taken.
- i_jump_ID  in  1  J/JAL/JR/JALR in ID.
- i_rt_EX  in  5  rt in EX.
- i_rd_EX  in  5  rd in EX.
- i_flg_ALU_dst_EX  in  2  destination select in EX: 00 rt, 01 rd, 11 r31, 10 none.
- i_flg_reg_wr_en_EX  in  1  EX instruction writes the register file.
- i_flg_mem_rd_EX  in  1  EX instruction is a load.
- i_rt_MEM  in  5  rt in MEM.
- i_rd_MEM  in  5  rd in MEM.
- i_flg_ALU_dst_MEM  in  2  destination select in MEM (same encoding as EX).
- i_flg_reg_wr_en_MEM  in  1  MEM instruction writes the register file.
- i_flg_mem_rd_MEM  in  1  MEM instruction is a load.
- i_halt_WB  in  1  HALT instruction in WB.
- o_pc_wr_en  out  1  PC write enable.
- o_IF_ID_wr_en  out  1  IF/ID write enable.
- o_ID_EX_bubble  out  1  load a NOP into ID/EX (all control flags zero).
- o_IF_ID_flush  out  1  load a NOP into IF/ID.
- o_halted  out  1  pipeline halted.
- o_stall_count  out  CNT_W  count of stall cycles, saturating.
- o_flush_count  out  CNT_W  count of flush cycles, saturating.

Behaviour:
- Destination decode, per stage:
  - dst = rt for 00, rd for 01, 31 for 11.
  - Select 10, wr_en=0, or dst==0 means no destination; such a stage never matches.
- Match(stage) = (i_uses_rs_ID & i_rs_ID==dst) | (i_uses_rt_ID & i_rt_ID==dst).
- Hazard terms, evaluated combinationally:
  - H_LU = mem_rd_EX & Match(EX): 1 stall.
  - H_BA = branch_ID & ~mem_rd_EX & Match(EX): 1 stall.
  - H_BL2 = branch_ID & mem_rd_EX & Match(EX): 2 stalls.
  - H_BL1 = branch_ID & mem_rd_MEM & Match(MEM): 1 stall.
- FSM states: RUN, STALL2, HALTED. Reset state is RUN.
- Stall outputs: pc_wr_en=0, IF_ID_wr_en=0, bubble=1, flush=0.
- Output priority, highest first:
  1. Reset asserted: every output 0, counters 0.
  2. HALTED: all enables 0, bubble=0, flush=0, o_halted=1.
  3. i_run_en=0: all enables 0, bubble=0, flush=0. FSM and counters hold.
  4. STALL2: stall outputs unconditionally, independent of inputs. Next state RUN.
  5. RUN with any hazard term: stall outputs. Next state STALL2 if H_BL2, else RUN.
  6. RUN, no hazard, (i_branch_taken_ID | i_jump_ID): pc_wr_en=1, IF_ID_wr_en=1, flush=1, bubble=0.
  7. Otherwise: pc_wr_en=1, IF_ID_wr_en=1, bubble=0, flush=0.
- A hazard masks a taken/jump flush in the same cycle. The branch re-resolves once its operands are available.
- Stall and flush outputs are Mealy, with zero latency, so they take effect on the same clock edge as the hazard.
- Halt:
  - i_halt_WB=1 while i_run_en=1 moves the FSM to HALTED at the next edge, from RUN or from STALL2.
  - The current cycle's outputs still follow rules 4-7.
  - HALTED is sticky until reset.
- Counters:
  - o_stall_count increments on every edge where bubble=1.
  - o_flush_count increments on every edge where flush=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-stall returns the block to RUN immediately (asynchronously); outputs drop to 0 and counters clear.
- After reset deassertion, the first cycle behaves as RUN.

Test Plan:
- Load-use:
  - Stimulus: EX = lw to rt=5 (dst 00, mem_rd=1, wr_en=1); ID uses rs=5.
  - Response: exactly 1 cycle with pc_wr_en=0, IF_ID_wr_en=0, bubble=1.
  - Next cycle, with EX = bubble: all enables 1. o_stall_count=1.
- Branch after load:
  - Stimulus: EX = lw to r7; ID = beq rs=7, branch_ID=1.
  - Response: bubble=1 for 2 consecutive cycles, the second from STALL2 with EX/MEM inputs driven to zero, then normal. o_stall_count=2.
- Branch after ALU op:
  - Stimulus: EX = add rd=3 (dst 01, wr_en=1); ID = bne rt=3.
  - Response: 1 stall cycle.
  - Repeat with rd=0 or select 10: no stall.
- Taken branch with no hazard:
  - Stimulus: branch_taken_ID=1.
  - Response: flush=1, pc_wr_en=1 for one cycle. o_flush_count=1.
  - Repeat with an H_BA hazard present: flush=0, bubble=1.
- Halt and freeze:
  - Stimulus: i_halt_WB=1 for one cycle.
  - Response: next cycle onward, o_halted=1 and all enables 0 regardless of inputs.
  - i_run_en=0 in RUN: enables 0 and counters frozen.
- Async reset in STALL2:
  - Stimulus: drop i_rst_n mid-cycle.
  - Response: outputs 0 without waiting for a clock edge.
  - After release: RUN, counters 0, o_halted=0.
